// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state type, default widths and the zero-to-one clamp for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} t_rst_seq_state;
  localparam int NB_RST_DEF = 4;
  localparam int CNT_W_DEF = 16;
  function automatic int unsigned f_min1(input int unsigned cnt);
    return (cnt == 0) ? 1 : cnt;
  endfunction
endpackage

// File: rtl/tb_dwn_cnt.sv
// tb_dwn_cnt: loadable down counter that stops at zero
// ports: clk, rst (sync, active high), load/load_val (load wins over en), en (decrement),
//        last (count currently equals 1, i.e. the interval expires at this edge)
module tb_dwn_cnt #(
  parameter int G_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [G_CNT_W-1:0] load_val,
  input  logic               en,
  output logic               last
);
  logic [G_CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign last = cnt == G_CNT_W'(1);
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: holds all DUT resets low for a programmable width, then releases them in index order with a stagger
// ports: clk_tb, rst (sync, active high), start_i (accepted only in IDLE), assert_cyc_i (low width, 0 acts as 1),
//        stagger_cyc_i (spacing between releases, 0 releases all at once), busy_o, done_o (one-cycle pulse),
//        rst_n_o (active-low resets, all registered)
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int G_NB_RST = NB_RST_DEF,
  parameter int G_CNT_W  = CNT_W_DEF
) (
  input  logic                clk_tb,
  input  logic                rst,
  input  logic                start_i,
  input  logic [G_CNT_W-1:0]  assert_cyc_i,
  input  logic [G_CNT_W-1:0]  stagger_cyc_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [G_NB_RST-1:0] rst_n_o
);
  localparam int IDX_W = $clog2(G_NB_RST) + 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(G_NB_RST);
  t_rst_seq_state state, state_nx;
  logic [G_CNT_W-1:0] s_q, s_nx, a_val;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [G_NB_RST-1:0] rst_n_nx;
  logic busy_nx, done_nx, all_at_once;
  logic a_ld, a_en, a_last, s_ld, s_en, s_last;
  assign a_val = G_CNT_W'(f_min1(32'(assert_cyc_i)));
  // a zero stagger, or a single line, finishes every release on the first one
  assign all_at_once = (s_q == '0) || (G_NB_RST == 1);
  tb_dwn_cnt #(.G_CNT_W(G_CNT_W)) u_assert_cnt (
    .clk(clk_tb), .rst(rst), .load(a_ld), .load_val(a_val), .en(a_en), .last(a_last)
  );
  tb_dwn_cnt #(.G_CNT_W(G_CNT_W)) u_stagger_cnt (
    .clk(clk_tb), .rst(rst), .load(s_ld), .load_val(s_q), .en(s_en), .last(s_last)
  );
  always_ff @(posedge clk_tb)
    if (rst) begin
      state   <= IDLE;
      s_q     <= '0;
      idx     <= '0;
      rst_n_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nx;
      s_q     <= s_nx;
      idx     <= idx_nx;
      rst_n_o <= rst_n_nx;
      busy_o  <= busy_nx;
      done_o  <= done_nx;
    end
  always_comb begin
    state_nx = state;
    s_nx     = s_q;
    idx_nx   = idx;
    rst_n_nx = rst_n_o;
    busy_nx  = busy_o;
    done_nx  = 1'b0;
    a_ld     = 1'b0;
    a_en     = 1'b0;
    s_ld     = 1'b0;
    s_en     = 1'b0;
    case (state)
      IDLE:
        if (start_i) begin
          state_nx = ASSERT;
          s_nx     = stagger_cyc_i;
          idx_nx   = '0;
          rst_n_nx = '0;
          busy_nx  = 1'b1;
          a_ld     = 1'b1;
        end
      ASSERT: begin
        a_en = 1'b1;
        if (a_last) begin
          state_nx = RELEASE;
          rst_n_nx = all_at_once ? '1 : (rst_n_o | G_NB_RST'(1));
          idx_nx   = all_at_once ? IDX_MAX : IDX_W'(1);
          s_ld     = !all_at_once;
        end
      end
      // idx saturated means the last line went high at the previous edge
      RELEASE:
        if (idx == IDX_MAX) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          s_en = 1'b1;
          if (s_last) begin
            rst_n_nx = rst_n_o | (G_NB_RST'(1) << idx);
            idx_nx   = idx + 1'b1;
            s_ld     = 1'b1;
          end
        end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule
